// File: rtl/mem_bus_master.sv
// Initiator for the 32x8 async-strobe memory: turns a valid/ready request into setup/strobe/hold bus cycles.
// Optional write read-back verify is enabled by defining MEM_BUS_MASTER_VERIFY_EN.
module mem_bus_master #(
  parameter int READ_WAIT   = 1,
  parameter int WRITE_PULSE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [4:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  inout  wire  [7:0] data,
  output logic [4:0] addr,
  output logic       read,
  output logic       write,
  output logic [3:0] dbg_state
);

  // Handshake: a request transfers on a rising edge with req_valid and req_ready both high;
  // req_ready is high only in IDLE. rsp_valid is a one-cycle pulse with no backpressure.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_W_SETUP  = 4'd1,
    S_W_STROBE = 4'd2,
    S_W_HOLD   = 4'd3,
    S_R_STROBE = 4'd4,
    S_R_TURN   = 4'd5
`ifdef MEM_BUS_MASTER_VERIFY_EN
    ,
    S_V_GAP    = 4'd6,
    S_V_STROBE = 4'd7,
    S_V_TURN   = 4'd8
`endif
  } state_t;

  localparam logic [3:0] RW_LOAD = 4'(READ_WAIT);
  localparam logic [3:0] WP_LOAD = 4'(WRITE_PULSE - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       read_q, read_d;
  logic       write_q, write_d;
  logic       oe_q, oe_d;
`ifdef MEM_BUS_MASTER_VERIFY_EN
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    read_d      = 1'b0;
    write_d     = 1'b0;
    oe_d        = 1'b0;
`ifdef MEM_BUS_MASTER_VERIFY_EN
    err_d       = 1'b0;
`endif
    // Outputs are computed for the state being entered so every bus pin comes straight from a flop.
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_we) begin
            state_d = S_W_SETUP;
            oe_d    = 1'b1;
          end else begin
            state_d = S_R_STROBE;
            read_d  = 1'b1;
            cnt_d   = RW_LOAD;
          end
        end
      end
      S_W_SETUP: begin
        state_d = S_W_STROBE;
        write_d = 1'b1;
        oe_d    = 1'b1;
        cnt_d   = WP_LOAD;
      end
      S_W_STROBE: begin
        oe_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_W_HOLD;
`ifndef MEM_BUS_MASTER_VERIFY_EN
          rsp_valid_d = 1'b1;
`endif
        end else begin
          cnt_d   = cnt_q - 4'd1;
          write_d = 1'b1;
        end
      end
      S_W_HOLD: begin
`ifdef MEM_BUS_MASTER_VERIFY_EN
        state_d = S_V_GAP;
`else
        state_d = S_IDLE;
`endif
      end
      S_R_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_R_TURN;
          rdata_d     = data;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          read_d = 1'b1;
        end
      end
      S_R_TURN: state_d = S_IDLE;
`ifdef MEM_BUS_MASTER_VERIFY_EN
      S_V_GAP: begin
        state_d = S_V_STROBE;
        read_d  = 1'b1;
        cnt_d   = RW_LOAD;
      end
      S_V_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_V_TURN;
          rdata_d     = data;
          rsp_valid_d = 1'b1;
          err_d       = (data != wdata_q);
        end else begin
          cnt_d  = cnt_q - 4'd1;
          read_d = 1'b1;
        end
      end
      S_V_TURN: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 5'd0;
      wdata_q     <= 8'd0;
      rdata_q     <= 8'd0;
      rsp_valid_q <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      oe_q        <= 1'b0;
`ifdef MEM_BUS_MASTER_VERIFY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      read_q      <= read_d;
      write_q     <= write_d;
      oe_q        <= oe_d;
`ifdef MEM_BUS_MASTER_VERIFY_EN
      err_q       <= err_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
`ifdef MEM_BUS_MASTER_VERIFY_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif
  assign addr      = addr_q;
  assign read      = read_q;
  assign write     = write_q;
  assign data      = oe_q ? wdata_q : 8'bz;
  assign dbg_state = state_q;

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator for the team's 32x8 asynchronous-strobe memory: shared 8-bit tri-state data bus, 5-bit addr, level `read`, edge-captured `write` (memory latches on rising edge of `write`).
- Converts a synchronous valid/ready request port into correctly sequenced setup/strobe/hold bus cycles and returns read data on a response pulse.
- Sits between the core's load/store unit and the memory instance.

Parameters:
- READ_WAIT, 1, extra cycles `read` stays high before data capture (0..15)
- WRITE_PULSE, 1, cycles `write` stays high (1..15)

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  master can accept a request (high only in IDLE)
- req_we  input  1  1 = write, 0 = read
- req_addr  input  5  target address
- req_wdata  input  8  write data
- rsp_valid  output  1  one-cycle completion pulse, no backpressure
- rsp_rdata  output  8  read data; holds last read value
- rsp_err  output  1  verify mismatch flag, valid with rsp_valid
- data  inout  8  memory data bus, driven only during write phases, else 8'bz
- addr  output  5  memory address
- read  output  1  memory read enable
- write  output  1  memory write strobe

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - State IDLE.
  - req_ready=1 (combinational from IDLE).
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, addr=0, read=0, write=0.
  - Data output enable=0, so `data`=z. Takes effect immediately on rst_n low.
- Outputs: all registered except req_ready. `data` is driven from a registered value and a registered output enable.
- Accept: a request is accepted on the rising edge where req_valid & req_ready. addr, we and wdata are latched at that edge and held stable for the whole transaction.
- Write sequence:
  - W_SETUP: 1 cycle. write=0, data driven.
  - W_STROBE: WRITE_PULSE cycles. write=1, data driven.
  - W_HOLD: 1 cycle. write=0, data still driven, rsp_valid=1.
  - Then IDLE.
  - Default latency: rsp_valid is high in the 3rd cycle after the accept edge (2+WRITE_PULSE).
- Read sequence:
  - R_STROBE: READ_WAIT+1 cycles. read=1, data=z. Capture `data` into rsp_rdata on the last R_STROBE edge.
  - R_TURN: 1 cycle. read=0, rsp_valid=1, rsp_rdata valid.
  - Then IDLE.
  - Default latency: rsp_valid in the 3rd cycle after accept.
- Bus safety:
  - read and write are never high together.
  - Output enable is never high while read=1.
  - IDLE (at least 1 cycle) always separates transactions, giving a turnaround cycle between read and write.
- Wait counter: 4 bits, loaded on state entry, counts down to 0. With READ_WAIT=0, R_STROBE lasts exactly 1 cycle.
- req_valid while busy: ignored; the request stays pending at the requester until IDLE.
- rsp_err: 0 whenever verify is not in use.
- Reset mid-operation: the transaction is aborted with no response.
  - write falls immediately. A write strobe already risen has been captured by the memory; otherwise no write occurs.
  - After reset release, the first accept is possible on the first clk edge.
- Address: wrap is not applicable; all 32 addresses are legal.

Optional Feature:
- Macro MEM_BUS_MASTER_VERIFY_EN.
- Defined: every write is followed by read-back.
  - Sequence: W_HOLD (rsp_valid=0) → V_GAP (1 cycle, bus idle) → V_STROBE (READ_WAIT+1 cycles, read=1) → V_TURN (rsp_valid=1).
  - rsp_err=1 if the captured byte ≠ latched wdata.
  - rsp_rdata is updated with the read-back byte.
  - Write latency grows by READ_WAIT+3.
- Undefined: states V_* are absent and rsp_err is tied 0.

Test Plan:
- Reset: assert rst_n=0 mid W_STROBE → write, read, rsp_valid drop to 0 and data=z without a clk edge. After release, req_ready=1.
- Write then read: write addr 5'h0A data 8'h5C, then read 5'h0A → write pulse is 1 cycle, rsp_valid in cycle 3 after each accept, rsp_rdata=8'h5C.
- Back-to-back: req_valid held high with 4 alternating writes/reads to 5'h00 and 5'h1F (8'hFF, 8'h01) → each completes.
  - req_ready low while busy.
  - Never read&write, never drive while read=1.
  - Read-back values correct.
- Parameters: READ_WAIT=0, WRITE_PULSE=3 → write high exactly 3 cycles; read high exactly 1 cycle; rsp_valid at cycles 5 and 2 after accept.
- Verify (macro on): memory model forced to corrupt addr 5'h03; write 8'hA5 → rsp_valid once after V_TURN with rsp_err=1. Write to 5'h04 gives rsp_err=0.
- Idle bus: no requests for 20 cycles → data=z, read=write=0, rsp_valid=0 throughout.
